// File: rtl/prod_accum_ctrl.sv
// ---------------------------------------------------------------------------
// prod_accum_ctrl : sequences chunked tree ops and folds results into a sum.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prod_accum_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHUNKS = 16,
  parameter int CHUNK_W    = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  start_op_sel_i,
  input  logic [CHUNK_W-1:0]    start_num_chunks_i,
  output logic                  busy_o,
  output logic                  chunk_req_o,
  output logic [CHUNK_W-1:0]    chunk_idx_o,
  input  logic                  chunk_rdy_i,
  output logic                  tree_en_o,
  output logic                  tree_op_sel_o,
  input  logic [DATA_WIDTH-1:0] tree_data_i,
  input  logic                  tree_vld_i,
  output logic                  acc_en_o,
  output logic [DATA_WIDTH-1:0] acc_a_o,
  output logic [DATA_WIDTH-1:0] acc_b_o,
  input  logic [DATA_WIDTH-1:0] acc_data_i,
  input  logic                  acc_vld_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_vld_o,
  output logic                  err_timeout_o
);

  localparam int                  WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]     C_WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CHUNK_W-1:0]  C_MAX_N   = CHUNK_W'(MAX_CHUNKS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_FIRE      = 3'd2,
    S_WAIT_TREE = 3'd3,
    S_ACCUM     = 3'd4,
    S_WAIT_ACC  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                state_q,  state_d;
  logic                  op_sel_q, op_sel_d;
  logic [CHUNK_W-1:0]    num_q,    num_d;
  logic [CHUNK_W-1:0]    idx_q,    idx_d;
  logic [DATA_WIDTH-1:0] sum_q,    sum_d;
  logic [DATA_WIDTH-1:0] chunk_q,  chunk_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  rvld_q,   rvld_d;
  logic                  err_q,    err_d;
  logic [WD_W-1:0]       wdog_q,   wdog_d;

  logic [CHUNK_W-1:0]    w_num_sat;
  logic                  w_last;

  assign w_num_sat = (start_num_chunks_i > C_MAX_N) ? C_MAX_N : start_num_chunks_i;
  assign w_last    = (idx_q == (num_q - CHUNK_W'(1)));

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    num_d    = num_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    chunk_d  = chunk_q;
    result_d = result_q;
    rvld_d   = 1'b0;
    err_d    = 1'b0;
    wdog_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_sel_d = start_op_sel_i;
          num_d    = w_num_sat;
          idx_d    = '0;
          if (w_num_sat == '0) begin
            sum_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (chunk_rdy_i) state_d = S_FIRE;
      end
      S_FIRE: state_d = S_WAIT_TREE;
      S_WAIT_TREE: begin
        // A valid in the final watchdog cycle takes priority over the abort.
        if (tree_vld_i) begin
          chunk_d = tree_data_i;
          if (idx_q == '0) begin
            sum_d = tree_data_i;
            if (w_last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + CHUNK_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_ACCUM;
          end
        end else if (wdog_q == C_WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_ACCUM: state_d = S_WAIT_ACC;
      S_WAIT_ACC: begin
        if (acc_vld_i) begin
          sum_d = acc_data_i;
          if (w_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + CHUNK_W'(1);
            state_d = S_FETCH;
          end
        end else if (wdog_q == C_WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DONE: begin
        result_d = sum_q;
        rvld_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_sel_q <= 1'b0;
      num_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      chunk_q  <= '0;
      result_q <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      chunk_q  <= chunk_d;
      result_q <= result_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // DONE counts as busy; the result/error pulse lands in the following IDLE cycle.
  assign busy_o        = (state_q != S_IDLE);
  assign chunk_req_o   = (state_q == S_FETCH);
  assign tree_en_o     = (state_q == S_FIRE);
  assign acc_en_o      = (state_q == S_ACCUM);
  assign chunk_idx_o   = idx_q;
  assign tree_op_sel_o = op_sel_q;
  assign acc_a_o       = sum_q;
  assign acc_b_o       = chunk_q;
  assign result_o      = result_q;
  assign result_vld_o  = rvld_q;
  assign err_timeout_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prod_accum_ctrl : directed bench with buffer, tree and adder models.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prod_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        start_op_sel_i = 1'b0;
  logic [4:0]  start_num_chunks_i = '0;
  logic        busy_o, chunk_req_o, chunk_rdy_i, tree_en_o, tree_op_sel_o;
  logic [4:0]  chunk_idx_o;
  logic [31:0] tree_data_i, acc_a_o, acc_b_o, acc_data_i, result_o;
  logic        tree_vld_i, acc_en_o, acc_vld_i, result_vld_o, err_timeout_o;

  prod_accum_ctrl #(.DATA_WIDTH(32), .MAX_CHUNKS(16), .CHUNK_W(5), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .start_op_sel_i(start_op_sel_i), .start_num_chunks_i(start_num_chunks_i),
    .busy_o(busy_o), .chunk_req_o(chunk_req_o), .chunk_idx_o(chunk_idx_o), .chunk_rdy_i(chunk_rdy_i),
    .tree_en_o(tree_en_o), .tree_op_sel_o(tree_op_sel_o), .tree_data_i(tree_data_i), .tree_vld_i(tree_vld_i),
    .acc_en_o(acc_en_o), .acc_a_o(acc_a_o), .acc_b_o(acc_b_o), .acc_data_i(acc_data_i), .acc_vld_i(acc_vld_i),
    .result_o(result_o), .result_vld_o(result_vld_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus-side knobs (written by the main sequence only)
  int          rdy_delay = 0;
  logic        tree_mute = 1'b0;
  logic [31:0] tree_tab [16];

  // Monitor-side records (written by the model process only)
  int          cyc = 0, n_req = 0, n_tree_en = 0, n_acc_en = 0, n_rvld = 0, n_err_to = 0;
  int          start_cyc = 0, req_rise_cyc = 0, tree_en_cyc = 0, rvld_cyc = 0, err_cyc = 0;
  logic [31:0] rvld_val = '0;
  logic        rvld_busy = 1'b0, err_busy = 1'b0, prev_req = 1'b0;
  logic [4:0]  idx_log [64];
  logic        op_log  [64];
  logic [31:0] a_log   [64];
  logic [31:0] b_log   [64];
  int          req_cnt = 0, tree_cnt = 0, tree_idx = 0, acc_cnt = 0;
  logic [31:0] acc_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_40800000: return 32'h40E00000;
      64'h40400000_40000000: return 32'h40A00000;
      default:               return a ^ b;
    endcase
  endfunction

  initial begin
    chunk_rdy_i = 1'b0; tree_vld_i = 1'b0; tree_data_i = '0;
    acc_vld_i = 1'b0; acc_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (start_i && !busy_o) start_cyc = cyc;
      if (chunk_req_o && !prev_req) req_rise_cyc = cyc;
      prev_req = chunk_req_o;
      if (chunk_req_o) n_req++;
      if (tree_en_o) begin
        if (n_tree_en < 64) begin
          idx_log[n_tree_en] = chunk_idx_o;
          op_log[n_tree_en]  = tree_op_sel_o;
        end
        n_tree_en++;
        tree_en_cyc = cyc;
      end
      if (acc_en_o) begin
        if (n_acc_en < 64) begin
          a_log[n_acc_en] = acc_a_o;
          b_log[n_acc_en] = acc_b_o;
        end
        n_acc_en++;
      end
      if (result_vld_o) begin
        n_rvld++; rvld_cyc = cyc; rvld_val = result_o; rvld_busy = busy_o;
      end
      if (err_timeout_o) begin
        n_err_to++; err_cyc = cyc; err_busy = busy_o;
      end
      // operand buffer: rdy after rdy_delay cycles of request
      if (chunk_req_o) begin
        chunk_rdy_i = (req_cnt == rdy_delay);
        req_cnt++;
      end else begin
        chunk_rdy_i = 1'b0;
        req_cnt = 0;
      end
      // tree: valid 3 cycles after tree_en
      tree_vld_i = 1'b0;
      if (tree_cnt > 0) begin
        tree_cnt--;
        if (tree_cnt == 0 && !tree_mute) begin
          tree_vld_i  = 1'b1;
          tree_data_i = tree_tab[tree_idx];
        end
      end
      if (tree_en_o) begin
        tree_cnt = 3;
        tree_idx = int'(chunk_idx_o);
      end
      // adder: valid 2 cycles after acc_en
      acc_vld_i = 1'b0;
      if (acc_cnt > 0) begin
        acc_cnt--;
        if (acc_cnt == 0) begin
          acc_vld_i  = 1'b1;
          acc_data_i = acc_res;
        end
      end
      if (acc_en_o) begin
        acc_cnt = 2;
        acc_res = fp_add(acc_a_o, acc_b_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic op, input logic [4:0] n);
    start_i = 1'b1; start_op_sel_i = op; start_num_chunks_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int rv0, input int er0);
    for (int i = 0; i < budget && n_rvld == rv0 && n_err_to == er0; i++) tick();
    if (n_rvld == rv0 && n_err_to == er0) check("wait_budget", n_rvld - rv0 + n_err_to - er0, 1);
    repeat (3) tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {25'd0, busy_o, chunk_req_o, tree_en_o, acc_en_o, result_vld_o, err_timeout_o, tree_op_sel_o}, 32'd0);
    check({tag, "_idx"},    {27'd0, chunk_idx_o}, 32'd0);
    check({tag, "_acc_a"},  acc_a_o,  32'd0);
    check({tag, "_acc_b"},  acc_b_o,  32'd0);
    check({tag, "_result"}, result_o, 32'd0);
  endtask

  initial begin
    int rv0, er0, t0, a0, q0;
    for (int i = 0; i < 16; i++) tree_tab[i] = '0;
    repeat (3) tick();
    check_reset_outs("reset");
    rst = 1'b0;
    tick();

    // single chunk, no adder op
    tree_tab[0] = 32'h40A00000;
    rv0 = n_rvld; er0 = n_err_to; a0 = n_acc_en;
    start_job(1'b0, 5'd1);
    wait_done(60, rv0, er0);
    check("single_acc_en", n_acc_en - a0, 0);
    check("single_result", rvld_val, 32'h40A00000);
    check("single_nrvld",  n_rvld - rv0, 1);
    check("single_busy",   {31'd0, rvld_busy}, 32'd0);
    check("single_lat",    rvld_cyc - start_cyc, 7);

    // three chunks folded through the adder
    tree_tab[0] = 32'h3F800000; tree_tab[1] = 32'h40000000; tree_tab[2] = 32'h40800000;
    rv0 = n_rvld; er0 = n_err_to; a0 = n_acc_en; t0 = n_tree_en;
    start_job(1'b1, 5'd3);
    wait_done(100, rv0, er0);
    check("three_acc_en", n_acc_en - a0, 2);
    check("three_a0", a_log[a0],     32'h3F800000);
    check("three_b0", b_log[a0],     32'h40000000);
    check("three_a1", a_log[a0 + 1], 32'h40400000);
    check("three_b1", b_log[a0 + 1], 32'h40800000);
    check("three_result", rvld_val, 32'h40E00000);
    check("three_idx0", {27'd0, idx_log[t0]},     32'd0);
    check("three_idx1", {27'd0, idx_log[t0 + 1]}, 32'd1);
    check("three_idx2", {27'd0, idx_log[t0 + 2]}, 32'd2);
    check("three_op",   {31'd0, op_log[t0]},      32'd1);

    // zero-length job
    rv0 = n_rvld; er0 = n_err_to; t0 = n_tree_en; q0 = n_req;
    start_job(1'b0, 5'd0);
    wait_done(20, rv0, er0);
    check("zero_req",    n_req - q0, 0);
    check("zero_tree",   n_tree_en - t0, 0);
    check("zero_result", rvld_val, 32'd0);
    check("zero_lat",    rvld_cyc - start_cyc, 2);

    // back-pressure plus ignored starts
    rdy_delay = 5;
    tree_tab[0] = 32'h41200000;
    rv0 = n_rvld; er0 = n_err_to; t0 = n_tree_en; q0 = n_req;
    start_job(1'b0, 5'd1);
    tick();
    start_job(1'b1, 5'd3);
    tick();
    start_job(1'b1, 5'd2);
    wait_done(100, rv0, er0);
    repeat (10) tick();
    check("bp_req_cycles", n_req - q0, 6);
    check("bp_tree_after", tree_en_cyc - req_rise_cyc, 6);
    check("bp_tree_count", n_tree_en - t0, 1);
    check("bp_nrvld",      n_rvld - rv0, 1);
    check("bp_result",     rvld_val, 32'h41200000);
    check("bp_busy_after", {31'd0, busy_o}, 32'd0);
    rdy_delay = 0;

    // watchdog abort on a silent tree
    tree_mute = 1'b1;
    rv0 = n_rvld; er0 = n_err_to;
    start_job(1'b0, 5'd1);
    wait_done(60, rv0, er0);
    check("to_lat",    err_cyc - tree_en_cyc, 9);
    check("to_busy",   {31'd0, err_busy}, 32'd0);
    check("to_nerr",   n_err_to - er0, 1);
    check("to_nrvld",  n_rvld - rv0, 0);
    check("to_result", result_o, 32'h41200000);
    tree_mute = 1'b0;
    tree_tab[0] = 32'h3F800000;
    rv0 = n_rvld; er0 = n_err_to;
    start_job(1'b0, 5'd1);
    wait_done(60, rv0, er0);
    check("to_next_result", rvld_val, 32'h3F800000);
    check("to_next_nrvld",  n_rvld - rv0, 1);

    // reset during WAIT_ACC of a 4-chunk job
    tree_tab[0] = 32'h3F800000; tree_tab[1] = 32'h40000000;
    tree_tab[2] = 32'h40800000; tree_tab[3] = 32'h41000000;
    rv0 = n_rvld; er0 = n_err_to; a0 = n_acc_en;
    start_job(1'b1, 5'd4);
    for (int i = 0; i < 60 && n_acc_en == a0; i++) tick();
    check("mid_reached_accum", n_acc_en - a0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outs("mid_reset");
    repeat (6) tick();
    check("mid_busy",  {31'd0, busy_o}, 32'd0);
    check("mid_nrvld", n_rvld - rv0, 0);
    check("mid_acc_a", acc_a_o, 32'd0);
    tree_tab[0] = 32'h40400000;
    rv0 = n_rvld; er0 = n_err_to; a0 = n_acc_en;
    start_job(1'b0, 5'd1);
    wait_done(60, rv0, er0);
    check("mid_next_result", rvld_val, 32'h40400000);
    check("mid_next_acc",    n_acc_en - a0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire

// File: doc/prod_accum_ctrl.md
Name: prod_accum_ctrl

Overview:
- Sequences the 32-lane product/adder tree (prod_accum) to compute one SVM dot product or reduction over a feature vector of up to MAX_CHUNKS×32 elements.
- Requests each 32-element chunk from the operand buffer and fires the tree once per chunk.
- Folds the per-chunk tree results into a running sum through an external fp_arith accumulator instance.
- Returns one scalar result per job.

Parameters:
- DATA_WIDTH, 32, width of tree results, accumulator operands and job result.
- MAX_CHUNKS, 16, maximum chunks per job.
- CHUNK_W, 5, width of chunk count/index; must hold MAX_CHUNKS.
- TIMEOUT, 255, max wait cycles for tree_vld or acc_vld before aborting.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  job request; accepted only in IDLE.
- start_op_sel  in  1  tree operation select for the job.
- start_num_chunks  in  CHUNK_W  chunks in job (0..MAX_CHUNKS).
- busy  out  1  high from acceptance until the result/error cycle.
- chunk_req  out  1  request chunk chunk_idx from operand buffer.
- chunk_idx  out  CHUNK_W  chunk index, 0-based.
- chunk_rdy  in  1  buffer presents chunk on tree lanes; held while chunk_req high.
- tree_en  out  1  one-cycle fire pulse to tree (comp_en).
- tree_op_sel  out  1  latched start_op_sel (data_in_op_sel).
- tree_data  in  DATA_WIDTH  tree result (data_out).
- tree_vld  in  1  tree result valid (data_out_vld).
- acc_en  out  1  one-cycle fire pulse to accumulator adder.
- acc_a  out  DATA_WIDTH  running sum operand.
- acc_b  out  DATA_WIDTH  chunk result operand.
- acc_data  in  DATA_WIDTH  adder result.
- acc_vld  in  1  adder result valid.
- result  out  DATA_WIDTH  job result, held until next result/error.
- result_vld  out  1  one-cycle pulse on job completion.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: state=IDLE. busy, chunk_req, tree_en, acc_en, result_vld, err_timeout = 0. chunk_idx, tree_op_sel, acc_a, acc_b, result = 0. Running sum and watchdog cleared. Reset mid-job abandons the job; late tree_vld/acc_vld after reset are ignored.
- States: IDLE, FETCH, FIRE, WAIT_TREE, ACCUM, WAIT_ACC, DONE.
- IDLE:
  - On start: latch op_sel and num_chunks; chunk_idx=0.
  - If num_chunks=0: go to DONE with sum=0.
  - Otherwise: go to FETCH; busy=1 from the next cycle.
  - start while busy is ignored, not queued.
- FETCH: chunk_req=1 until chunk_rdy. On chunk_rdy: chunk_req drops next cycle, go to FIRE.
- FIRE: tree_en=1 for exactly one cycle, then WAIT_TREE.
- WAIT_TREE:
  - On tree_vld, capture tree_data.
  - If chunk_idx=0: sum := tree_data directly (no adder op). Then go to FETCH with idx+1, or to DONE if last chunk.
  - Otherwise: go to ACCUM.
- ACCUM: drive acc_a=sum, acc_b=captured chunk result; acc_en=1 for one cycle; go to WAIT_ACC.
- WAIT_ACC: on acc_vld, sum := acc_data. If chunk_idx=num_chunks-1 go to DONE, else idx+1 and FETCH.
- DONE: result := sum, result_vld=1 for one cycle, busy=0 in the same cycle, then IDLE. A new start is accepted the cycle after DONE.
- Tree and adder are never overlapped: at most one tree op and one adder op outstanding, strictly serialised.
- Watchdog:
  - Counts cycles in WAIT_TREE/WAIT_ACC; resets on entry to each.
  - When it reaches TIMEOUT without valid: pulse err_timeout, result unchanged, no result_vld, busy=0, go to IDLE.
  - Valid arriving in the same cycle as the timeout wins (no error).
- tree_vld/acc_vld outside their wait states are ignored.
- start_num_chunks > MAX_CHUNKS is saturated to MAX_CHUNKS.
- Latency, single-cycle chunk_rdy and single-cycle valids: 1 cycle accept, then per chunk FETCH 1 + FIRE 1 + tree latency. Chunks after the first add ACCUM 1 + adder latency. Plus 1 DONE cycle.

Test Plan:
- Single chunk: start num_chunks=1, op_sel=0; tree model returns 0x40A00000 (5.0) 3 cycles after tree_en -> no acc_en; result=0x40A00000, result_vld one pulse; busy low same cycle.
- Three chunks: tree returns 1.0, 2.0, 4.0 (0x3F800000, 0x40000000, 0x40800000); adder model latency 2 -> acc_en exactly twice with (a,b)=(1.0,2.0) then (3.0,4.0); result=0x40E00000; chunk_idx sequence 0,1,2.
- Zero-length: start num_chunks=0 -> no chunk_req/tree_en; result=0, result_vld 2 cycles after start.
- Back-pressure and ignored start: chunk_rdy delayed 5 cycles -> chunk_req held high throughout, tree_en only after rdy; start pulses while busy -> no effect, one result only.
- Timeout: TIMEOUT=8, tree never returns valid -> err_timeout pulse 8 cycles after entering WAIT_TREE, busy=0, result unchanged; next start runs normally.
- Reset mid-job: assert rst during WAIT_ACC of a 4-chunk job -> all outputs at reset values next cycle; stray acc_vld afterwards ignored; fresh 1-chunk job completes correctly.
